// File: rtl/nl_pkg.sv
// rtl/nl_pkg.sv - shared router types: port encodings, request record, credit width helper
package nl_pkg;
    localparam int NUM_PORTS = 5;
    localparam int PORT_W    = 3;

    typedef enum logic [PORT_W-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } port_idx_t;

    typedef struct packed {
        logic              valid;
        logic              head;
        logic              tail;
        logic [PORT_W-1:0] pri;
        logic [PORT_W-1:0] alt;
        logic              adapt;
        logic              pref_alt;
    } alloc_req_t;

    // Counter must hold the full buffer depth, so one more than depth-1.
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/nl_rr_arbiter.sv
// rtl/nl_rr_arbiter.sv - N-way round-robin arbiter, priority starts at ptr
module nl_rr_arbiter #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);
    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = W'(idx);
            end
        end
    end
endmodule

// File: rtl/nl_adaptive_switch_alloc.sv
// rtl/nl_adaptive_switch_alloc.sv - wormhole switch allocator with adaptive target choice and credit gating
module nl_adaptive_switch_alloc
    import nl_pkg::*;
#(
    parameter int NP        = 5,
    parameter int BUF_DEPTH = 8,
    parameter int PW        = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NP-1:0]          req_valid,
    input  logic [NP-1:0]          req_head,
    input  logic [NP-1:0]          req_tail,
    input  logic [NP-1:0][PW-1:0]  req_pri,
    input  logic [NP-1:0][PW-1:0]  req_alt,
    input  logic [NP-1:0]          req_adapt,
    input  logic [NP-1:0]          req_pref_alt,
    input  logic [NP-1:0]          credit_in,
    output logic [NP-1:0]          grant,
    output logic [NP-1:0][PW-1:0]  grant_port,
    output logic [NP-1:0]          out_valid,
    output logic [NP-1:0][PW-1:0]  out_src
);
    localparam int CW = credit_w(BUF_DEPTH);

    logic [NP-1:0]          own_valid;
    logic [NP-1:0][PW-1:0]  own_src;
    logic [NP-1:0][PW-1:0]  rr_ptr;
    logic [NP-1:0][CW-1:0]  cred;
    logic [NP-1:0]          in_lock;
    logic [NP-1:0][PW-1:0]  in_port;

    logic [NP-1:0]          cred_ok;
    logic [NP-1:0]          avail;
    logic [NP-1:0][PW-1:0]  target;
    logic [NP-1:0]          head_req;
    logic [NP-1:0]          body_req;
    logic [NP-1:0][NP-1:0]  arb_req;
    logic [NP-1:0][NP-1:0]  arb_gnt;
    logic [NP-1:0][PW-1:0]  arb_idx;

    function automatic logic port_avail(input logic [NP-1:0] vec, input logic [PW-1:0] p);
        return (int'(p) < NP) && vec[p];
    endfunction

    always_comb begin
        for (int o = 0; o < NP; o++) begin
            cred_ok[o] = (cred[o] != '0);
            avail[o]   = !own_valid[o] && cred_ok[o];
        end
    end

    // A head that finds neither candidate free stays on its preferred port and blocks there.
    always_comb begin
        alloc_req_t        r;
        logic [PW-1:0]     pref;
        logic [PW-1:0]     other;
        for (int i = 0; i < NP; i++) begin
            r = '{valid: req_valid[i], head: req_head[i], tail: req_tail[i], pri: req_pri[i],
                  alt: req_alt[i], adapt: req_adapt[i], pref_alt: req_pref_alt[i]};
            pref  = (r.adapt && r.pref_alt) ? r.alt : r.pri;
            other = (r.adapt && r.pref_alt) ? r.pri : r.alt;
            if (!r.head)
                target[i] = in_port[i];
            else if (port_avail(avail, pref))
                target[i] = pref;
            else if (r.adapt && port_avail(avail, other))
                target[i] = other;
            else
                target[i] = pref;
            head_req[i] = r.valid && r.head && (int'(target[i]) < NP);
            body_req[i] = r.valid && !r.head && in_lock[i];
        end
    end

    always_comb begin
        for (int o = 0; o < NP; o++) begin
            for (int i = 0; i < NP; i++) begin
                if (own_valid[o])
                    arb_req[o][i] = cred_ok[o] && body_req[i] && (in_port[i] == PW'(o))
                                    && (own_src[o] == PW'(i));
                else
                    arb_req[o][i] = cred_ok[o] && head_req[i] && (target[i] == PW'(o));
            end
        end
    end

    for (genvar o = 0; o < NP; o++) begin : g_arb
        nl_rr_arbiter #(.N(NP), .W(PW)) u_arb (
            .req     (arb_req[o]),
            .ptr     (rr_ptr[o]),
            .gnt     (arb_gnt[o]),
            .gnt_idx (arb_idx[o])
        );
    end

    always_comb begin
        grant      = '0;
        grant_port = '0;
        out_valid  = '0;
        out_src    = '0;
        if (rst_n) begin
            for (int o = 0; o < NP; o++) begin
                if (|arb_gnt[o]) begin
                    out_valid[o] = 1'b1;
                    out_src[o]   = arb_idx[o];
                end
                for (int i = 0; i < NP; i++) begin
                    if (arb_gnt[o][i]) begin
                        grant[i]      = 1'b1;
                        grant_port[i] = PW'(o);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            own_valid <= '0;
            own_src   <= '0;
            rr_ptr    <= '0;
            in_lock   <= '0;
            in_port   <= '0;
            for (int o = 0; o < NP; o++) cred[o] <= CW'(BUF_DEPTH);
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (out_valid[o] && !credit_in[o])
                    cred[o] <= cred[o] - 1'b1;
                else if (!out_valid[o] && credit_in[o] && cred[o] < CW'(BUF_DEPTH))
                    cred[o] <= cred[o] + 1'b1;
                if (out_valid[o]) begin
                    if (req_head[out_src[o]]) begin
                        rr_ptr[o] <= (int'(out_src[o]) == NP - 1) ? '0 : out_src[o] + 1'b1;
                        if (!req_tail[out_src[o]]) begin
                            own_valid[o]        <= 1'b1;
                            own_src[o]          <= out_src[o];
                            in_lock[out_src[o]] <= 1'b1;
                            in_port[out_src[o]] <= PW'(o);
                        end
                    end else if (req_tail[out_src[o]]) begin
                        own_valid[o]        <= 1'b0;
                        in_lock[out_src[o]] <= 1'b0;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NP; i++)
                assert (!(req_valid[i] && !req_head[i] && !in_lock[i]));
            for (int o = 0; o < NP; o++)
                assert (!(credit_in[o] && !out_valid[o] && cred[o] == CW'(BUF_DEPTH)));
        end
    end
endmodule

// File: tb/tb_nl_adaptive_switch_alloc.sv
// tb/tb_nl_adaptive_switch_alloc.sv - directed self-checking bench for the switch allocator
module tb_nl_adaptive_switch_alloc;
    localparam int NP = 5;
    localparam int PW = 3;
    localparam logic [2:0] P_L = 3'd0, P_N = 3'd1, P_E = 3'd2, P_S = 3'd3, P_W = 3'd4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NP-1:0]         req_valid, req_head, req_tail, req_adapt, req_pref_alt, credit_in;
    logic [NP-1:0][PW-1:0] req_pri, req_alt;
    logic [NP-1:0]         grant, out_valid;
    logic [NP-1:0][PW-1:0] grant_port, out_src;

    int total = 0;
    int bad   = 0;

    nl_adaptive_switch_alloc #(.NP(NP), .BUF_DEPTH(8), .PW(PW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_head     (req_head),
        .req_tail     (req_tail),
        .req_pri      (req_pri),
        .req_alt      (req_alt),
        .req_adapt    (req_adapt),
        .req_pref_alt (req_pref_alt),
        .credit_in    (credit_in),
        .grant        (grant),
        .grant_port   (grant_port),
        .out_valid    (out_valid),
        .out_src      (out_src)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        req_valid    = '0;
        req_head     = '0;
        req_tail     = '0;
        req_pri      = '0;
        req_alt      = '0;
        req_adapt    = '0;
        req_pref_alt = '0;
        credit_in    = '0;
    endtask

    task automatic put(input int i, input logic h, input logic t, input logic [2:0] p,
                       input logic [2:0] a, input logic ad, input logic pa);
        req_valid[i]    = 1'b1;
        req_head[i]     = h;
        req_tail[i]     = t;
        req_pri[i]      = p;
        req_alt[i]      = a;
        req_adapt[i]    = ad;
        req_pref_alt[i] = pa;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        clr();
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        put(1, 1, 1, P_E, P_L, 0, 0);
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_grant_port", 32'(grant_port), 32'h0);
        chk("rst_out_src", 32'(out_src), 32'h0);
        rst_n = 1'b1;
        step();

        // 1: single-flit NORTH -> EAST
        put(1, 1, 1, P_E, P_L, 0, 0);
        #1;
        chk("t1_grant", 32'(grant), 32'b00010);
        chk("t1_grant_port_n", 32'(grant_port[1]), 32'(P_E));
        chk("t1_grant_port_l", 32'(grant_port[0]), 32'h0);
        chk("t1_out_valid", 32'(out_valid), 32'b00100);
        chk("t1_out_src_e", 32'(out_src[2]), 32'(P_N));

        // 2: LOCAL packet holds EAST; WEST head waits until after the tail
        step();
        put(0, 1, 0, P_E, P_L, 0, 0);
        #1;
        chk("t2_head", 32'(grant), 32'b00001);
        for (int k = 0; k < 3; k++) begin
            step();
            put(0, 0, 0, P_L, P_L, 0, 0);
            put(4, 1, 1, P_E, P_L, 0, 0);
            #1;
            chk("t2_body", 32'(grant), 32'b00001);
            chk("t2_body_src", 32'(out_src[2]), 32'(P_L));
        end
        step();
        put(0, 0, 1, P_L, P_L, 0, 0);
        put(4, 1, 1, P_E, P_L, 0, 0);
        #1;
        chk("t2_tail", 32'(grant), 32'b00001);
        step();
        put(4, 1, 1, P_E, P_L, 0, 0);
        #1;
        chk("t2_west", 32'(grant), 32'b10000);
        chk("t2_west_port", 32'(grant_port[4]), 32'(P_E));
        for (int k = 0; k < 4; k++) begin
            step();
            credit_in = 5'b00100;
        end

        // 3: round-robin S,W,S,W on NORTH
        for (int k = 0; k < 4; k++) begin
            step();
            put(3, 1, 1, P_N, P_L, 0, 0);
            put(4, 1, 1, P_N, P_L, 0, 0);
            #1;
            chk("t3_rr_grant", 32'(grant), (k % 2 == 0) ? 32'b01000 : 32'b10000);
            chk("t3_rr_src", 32'(out_src[1]), (k % 2 == 0) ? 32'(P_S) : 32'(P_W));
        end

        // 4: EAST owned by SOUTH; adaptive head falls back to primary NORTH
        step();
        put(3, 1, 0, P_E, P_L, 0, 0);
        #1;
        chk("t4_lock", 32'(grant), 32'b01000);
        step();
        put(0, 1, 1, P_N, P_E, 1, 1);
        #1;
        chk("t4_grant", 32'(grant), 32'b00001);
        chk("t4_port", 32'(grant_port[0]), 32'(P_N));
        chk("t4_out_valid", 32'(out_valid), 32'b00010);
        step();
        put(3, 0, 1, P_L, P_L, 0, 0);
        #1;
        chk("t4_release", 32'(grant), 32'b01000);

        // 5: NORTH packet drains SOUTH credits, stalls, resumes on credit return
        step();
        put(1, 1, 0, P_S, P_L, 0, 0);
        #1;
        chk("t5_head", 32'(grant), 32'b00010);
        for (int k = 0; k < 7; k++) begin
            step();
            put(1, 0, 0, P_L, P_L, 0, 0);
            #1;
            chk("t5_body", 32'(grant), 32'b00010);
        end
        step();
        put(1, 0, 0, P_L, P_L, 0, 0);
        put(0, 1, 1, P_S, P_L, 0, 0);
        credit_in = 5'b01000;
        #1;
        chk("t5_stall", 32'(grant), 32'h0);
        chk("t5_stall_ov", 32'(out_valid), 32'h0);
        step();
        put(1, 0, 0, P_L, P_L, 0, 0);
        credit_in = 5'b01000;
        #1;
        chk("t5_resume", 32'(grant), 32'b00010);
        step();
        put(1, 0, 0, P_L, P_L, 0, 0);
        #1;
        chk("t5_cred_kept", 32'(grant), 32'b00010);
        step();
        put(1, 0, 0, P_L, P_L, 0, 0);
        #1;
        chk("t5_drained", 32'(grant), 32'h0);

        // 6: three locks held, then reset mid-packet
        step();
        put(0, 1, 0, P_E, P_L, 0, 0);
        put(4, 1, 0, P_N, P_L, 0, 0);
        put(1, 0, 0, P_L, P_L, 0, 0);
        #1;
        chk("t6_locks", 32'(grant), 32'b10001);
        step();
        rst_n = 1'b0;
        put(0, 0, 0, P_L, P_L, 0, 0);
        put(4, 0, 0, P_L, P_L, 0, 0);
        put(1, 0, 0, P_L, P_L, 0, 0);
        #1;
        chk("t6_in_rst_grant", 32'(grant), 32'h0);
        chk("t6_in_rst_ov", 32'(out_valid), 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("t6_post_grant", 32'(grant), 32'h0);
        chk("t6_post_ov", 32'(out_valid), 32'h0);
        put(3, 1, 1, P_E, P_L, 0, 0);
        put(2, 1, 1, P_S, P_L, 0, 0);
        put(0, 1, 1, P_N, P_L, 0, 0);
        #1;
        chk("t6_new_grant", 32'(grant), 32'b01101);
        chk("t6_new_ov", 32'(out_valid), 32'b01110);
        chk("t6_new_src_s", 32'(out_src[3]), 32'(P_E));
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
